lsu_mem_master: RTL and testbench

LSU_MEM_MASTER -- requirements
Module: lsu_mem_master

---
 rtl/lsu_mem_master.sv | 152 +++++++++++++++
 tb/tb_lsu_mem_master.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// Load/store unit master: one core request in, one data-RAM access out, one response back.
// Latency: response 2 cycles after acceptance for a legal access, 1 cycle for a faulting one.
// Backpressure: a single transaction in flight; req_ready is low until the response handshakes.
//
// Ports:
//   clk, reset                    rising-edge clock, asynchronous active-high reset
//   req_valid/req_ready           core request handshake (req_we, req_addr, req_wdata, req_funct3)
//   resp_valid/resp_ready         core response handshake (resp_rdata, resp_err)
//   mem_we/addr/wdata/size        data-RAM request; mem_rdata is combinational read data at mem_addr
module lsu_mem_master (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_size,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        req_legal;
    logic        req_misal;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;

    // Request qualification is done on the raw inputs so a faulting request
    // can skip ACCESS entirely and never touch the RAM.
    always_comb begin
        req_legal = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: req_legal = 1'b1;
            3'b100, 3'b101:         req_legal = ~req_we;  // unsigned codes are load-only
            default:                req_legal = 1'b0;
        endcase
        req_misal = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                    ((req_funct3 == 3'b010) && (req_addr[1:0] != 2'b00));
    end

    // Lane extraction from the full RAM word using the registered address.
    always_comb begin
        ld_byte = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
        ld_half = mem_rdata[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'd0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'd0, ld_half};
            default: ld_data = mem_rdata;
        endcase
    end

    // State register (FSM and request/response holding registers).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'b010;   // word code so mem_size idles at 10
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            funct3_q <= funct3_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Next-state and register-update logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        funct3_d = funct3_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    we_d     = req_we;
                    funct3_d = req_funct3;
                    rdata_d  = 32'd0;
                    if (req_legal && !req_misal) begin
                        state_d = ACCESS;
                        err_d   = 1'b0;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                state_d = RESP;
                rdata_d = we_q ? 32'd0 : ld_data;
            end
            RESP: begin
                // Returning to IDLE here means the next request waits one
                // cycle, so acceptance never overlaps the response handshake.
                if (resp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: decoded from state_q so reset clears mem_we without waiting for a clock.
    always_comb begin
        req_ready  = (state_q == IDLE);
        resp_valid = (state_q == RESP);
        mem_we     = (state_q == ACCESS) && we_q;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        mem_addr   = addr_q;
        mem_wdata  = wdata_q;
        case (funct3_q)
            3'b000, 3'b100: mem_size = 2'b00;
            3'b001, 3'b101: mem_size = 2'b01;
            default:        mem_size = 2'b10;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [1:0]  mem_size;
    logic [31:0] mem_rdata;

    int n_assert = 0;
    int n_fail   = 0;

    // Write-cycle monitor: sampled mid-cycle, away from the active edge.
    int          wr_cnt = 0;
    logic [31:0] wr_addr = 32'd0;
    logic [31:0] wr_data = 32'd0;
    logic [1:0]  wr_size = 2'd0;

    lsu_mem_master dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_funct3 (req_funct3),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_size   (mem_size),
        .mem_rdata  (mem_rdata)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = mem_addr;
            wr_data = mem_wdata;
            wr_size = mem_size;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with immediate response acceptance.
    task automatic run(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [2:0] f3, input logic [31:0] mrd,
                       input logic exp_err, input logic [31:0] exp_rd, input logic [1:0] exp_sz);
        int wc0;
        wc0       = wr_cnt;
        mem_rdata = mrd;
        chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_addr   = addr;
        req_wdata  = wd;
        req_funct3 = f3;
        cyc();
        req_valid  = 1'b0;
        chk({tag, "_mem_size"}, 32'(mem_size), 32'(exp_sz));
        chk({tag, "_mem_addr"}, mem_addr, addr);
        chk({tag, "_mem_wdata"}, mem_wdata, wd);
        if (!exp_err) begin
            chk({tag, "_early_valid"}, 32'(resp_valid), 32'd0);
            chk({tag, "_mem_we"}, 32'(mem_we), 32'(we));
            cyc();
        end
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_resp_err"}, 32'(resp_err), 32'(exp_err));
        chk({tag, "_resp_rdata"}, resp_rdata, exp_rd);
        chk({tag, "_busy"}, 32'(req_ready), 32'd0);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk({tag, "_idle_valid"}, 32'(resp_valid), 32'd0);
        chk({tag, "_idle_ready"}, 32'(req_ready), 32'd1);
        chk({tag, "_writes"}, 32'(wr_cnt - wc0), 32'((we && !exp_err) ? 1 : 0));
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        req_funct3 = 3'b000;
        resp_ready = 1'b0;
        mem_rdata  = 32'd0;
        cyc();
        cyc();

        // Reset state
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_size", 32'(mem_size), 32'd2);
        reset = 1'b0;
        cyc();

        // Store byte
        run("sb", 1'b1, 32'h13, 32'hAB, 3'b000, 32'hDEADBEEF, 1'b0, 32'd0, 2'b00);
        chk("sb_wr_addr", wr_addr, 32'h13);
        chk("sb_wr_data", wr_data, 32'hAB);
        chk("sb_wr_size", 32'(wr_size), 32'd0);

        // Store half and word
        run("sh", 1'b1, 32'h46, 32'h1234, 3'b001, 32'd0, 1'b0, 32'd0, 2'b01);
        chk("sh_wr_size", 32'(wr_size), 32'd1);
        run("sw", 1'b1, 32'h48, 32'hCAFEF00D, 3'b010, 32'd0, 1'b0, 32'd0, 2'b10);
        chk("sw_wr_data", wr_data, 32'hCAFEF00D);

        // Byte loads
        run("lb21", 1'b0, 32'h21, 32'd0, 3'b000, 32'h80FF7F01, 1'b0, 32'h0000007F, 2'b00);
        run("lb22", 1'b0, 32'h22, 32'd0, 3'b000, 32'h80FF7F01, 1'b0, 32'hFFFFFFFF, 2'b00);
        run("lbu23", 1'b0, 32'h23, 32'd0, 3'b100, 32'h80FF7F01, 1'b0, 32'h00000080, 2'b00);

        // Half and word loads
        run("lh42", 1'b0, 32'h42, 32'd0, 3'b001, 32'h8001F00F, 1'b0, 32'hFFFF8001, 2'b01);
        run("lhu40", 1'b0, 32'h40, 32'd0, 3'b101, 32'h8001F00F, 1'b0, 32'h0000F00F, 2'b01);
        run("lw40", 1'b0, 32'h40, 32'd0, 3'b010, 32'h8001F00F, 1'b0, 32'h8001F00F, 2'b10);

        // Misaligned and illegal requests
        run("sw_mis", 1'b1, 32'h102, 32'h11111111, 3'b010, 32'hDEADBEEF, 1'b1, 32'd0, 2'b10);
        run("lh_mis", 1'b0, 32'h101, 32'd0, 3'b001, 32'hDEADBEEF, 1'b1, 32'd0, 2'b01);
        run("st_f4", 1'b1, 32'h104, 32'h22, 3'b100, 32'hDEADBEEF, 1'b1, 32'd0, 2'b00);
        run("ld_f3", 1'b0, 32'h108, 32'd0, 3'b011, 32'hDEADBEEF, 1'b1, 32'd0, 2'b10);

        // Backpressure: LH at 0x42, response held for 5 cycles while a new request waits
        mem_rdata  = 32'h8001F00F;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_addr   = 32'h42;
        req_funct3 = 3'b001;
        cyc();
        req_addr   = 32'h23;
        req_funct3 = 3'b100;
        cyc();
        chk("bp_first_valid", 32'(resp_valid), 32'd1);
        mem_rdata = 32'h00800000;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("bp_hold_valid", 32'(resp_valid), 32'd1);
            chk("bp_hold_rdata", resp_rdata, 32'hFFFF8001);
            chk("bp_hold_err", 32'(resp_err), 32'd0);
            chk("bp_hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk("bp_ret_valid", 32'(resp_valid), 32'd0);
        chk("bp_no_overlap", 32'(req_ready), 32'd1);
        mem_rdata = 32'h80FF7F01;
        cyc();
        req_valid = 1'b0;
        chk("bp_next_accept", 32'(req_ready), 32'd0);
        cyc();
        chk("bp_next_valid", 32'(resp_valid), 32'd1);
        chk("bp_next_rdata", resp_rdata, 32'h00000080);
        resp_ready = 1'b1;
        cyc();
        resp_ready = 1'b0;
        chk("bp_next_idle", 32'(req_ready), 32'd1);

        // Reset pulse during ACCESS of a store word
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_addr   = 32'h200;
        req_wdata  = 32'h12345678;
        req_funct3 = 3'b010;
        cyc();
        req_valid = 1'b0;
        chk("rp_mem_we_on", 32'(mem_we), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("rp_mem_we_drop", 32'(mem_we), 32'd0);
        cyc();
        reset = 1'b0;
        chk("rp_req_ready", 32'(req_ready), 32'd1);
        chk("rp_resp_rdata", resp_rdata, 32'd0);
        chk("rp_resp_err", 32'(resp_err), 32'd0);
        chk("rp_mem_addr", mem_addr, 32'd0);
        chk("rp_mem_wdata", mem_wdata, 32'd0);
        chk("rp_mem_size", 32'(mem_size), 32'd2);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("rp_no_resp", 32'(resp_valid), 32'd0);
            chk("rp_no_we", 32'(mem_we), 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
